// File: rtl/yarvi_pkg.sv
// Shared YARVI definitions: register-index and data widths, funct3 encodings,
// and the destination/source match used by the forwarding and hazard logic.
package yarvi_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  // x0 is never a real producer, so it can never match a source.
  function automatic logic rd_hits(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    return (rd != {REG_W{1'b0}}) && (rd == rs);
  endfunction

endpackage

// File: rtl/yarvi_regfile64.sv
// 32x64 register file: two combinational read ports, one write port.
// A read of the index being written in the same cycle returns the write data.
module yarvi_regfile64
  import yarvi_pkg::*;
(
  input  logic             clock,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage write; x0 is never stored.
  always_ff @(posedge clock) begin
    if (we && (wa != {REG_W{1'b0}})) begin
      regs_q[wa] <= wd;
    end
  end

  // Read port 1 with x0 and write-first bypass.
  always_comb begin
    rd1 = {XLEN{1'b0}};
    if (ra1 == {REG_W{1'b0}}) begin
      rd1 = {XLEN{1'b0}};
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_q[ra1];
    end
  end

  // Read port 2 with x0 and write-first bypass.
  always_comb begin
    rd2 = {XLEN{1'b0}};
    if (ra2 == {REG_W{1'b0}}) begin
      rd2 = {XLEN{1'b0}};
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_q[ra2];
    end
  end

endmodule

// File: rtl/yarvi_opfetch64.sv
// Operand-fetch stage: reads the register file, forwards the ALU result of the
// issued instruction, stalls one cycle on load-use, and registers the issue.
module yarvi_opfetch64
  import yarvi_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_load,
  input  logic             in_use_imm,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_insn30,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic             out_insn30,
  output logic [2:0]       out_funct3,
  output logic [REG_W-1:0] out_rd,
  output logic             out_we,
  output logic             out_load
);

  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic             load_use, accept, fwd1, fwd2;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic             insn30_q, insn30_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             we_q, we_d;
  logic             load_q, load_d;

  yarvi_regfile64 u_rf (
    .clock (clock),
    .ra1   (in_rs1),
    .ra2   (in_rs2),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (wb_valid),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // Hazard detection, forwarding selects and the accept handshake.
  always_comb begin
    load_use = valid_q && load_q && we_q &&
               (rd_hits(rd_q, in_rs1) || (!in_use_imm && rd_hits(rd_q, in_rs2)));
    fwd1     = valid_q && we_q && !load_q && rd_hits(rd_q, in_rs1);
    fwd2     = valid_q && we_q && !load_q && rd_hits(rd_q, in_rs2);
    in_ready = !reset && !flush && !load_use;
    accept   = in_valid && in_ready;
  end

  // Next issue register contents; a cycle without accept leaves a bubble.
  always_comb begin
    valid_d  = 1'b0;
    op1_d    = op1_q;
    op2_d    = op2_q;
    insn30_d = insn30_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    we_d     = we_q;
    load_d   = load_q;
    if (accept) begin
      valid_d  = 1'b1;
      op1_d    = fwd1 ? ex_result : rf_rd1;
      if (in_use_imm) begin
        op2_d = in_imm;
      end else begin
        op2_d = fwd2 ? ex_result : rf_rd2;
      end
      insn30_d = in_insn30;
      funct3_d = in_funct3;
      rd_d     = in_rd;
      we_d     = in_we;
      load_d   = in_load;
    end else begin
      valid_d  = 1'b0;
    end
  end

  // Issue register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      op1_q    <= {XLEN{1'b0}};
      op2_q    <= {XLEN{1'b0}};
      insn30_q <= 1'b0;
      funct3_q <= 3'b000;
      rd_q     <= {REG_W{1'b0}};
      we_q     <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      insn30_q <= insn30_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      load_q   <= load_d;
    end
  end

  assign out_valid  = valid_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign out_insn30 = insn30_q;
  assign out_funct3 = funct3_q;
  assign out_rd     = rd_q;
  assign out_we     = we_q;
  assign out_load   = load_q;

endmodule
